// File: rtl/isa_xcvr_controller.sv
// ISA I/O slave controller for an 8216 bidirectional transceiver pair.
//
// Decodes a 4-register I/O window at BASE_ADDR, sequences the transceiver chip
// select and direction, stretches the ISA cycle with IOCHRDY and generates
// one-cycle internal read/write strobes.
//
// Ports:
//   clk, rst         single clock, asynchronous active-high reset
//   isa_addr, aen    ISA SA[9:0] and AEN (AEN high blocks decode)
//   ior_n, iow_n     asynchronous ISA I/O strobes, active low
//   cs_n             8216 chip select, active low
//   dce              8216 direction (1 = ISA to internal, write)
//   iochrdy          ISA ready, low inserts wait states
//   reg_sel          register index latched from isa_addr[1:0]
//   wr_strobe        internal latch captures transceiver data
//   rd_strobe        internal source drives transceiver data
//   busy             controller not idle
//   strobe_err       sticky: both strobes seen low together
module isa_xcvr_controller #(
  parameter logic [9:0]  BASE_ADDR   = 10'h300,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] isa_addr,
  input  logic       aen,
  input  logic       ior_n,
  input  logic       iow_n,
  output logic       cs_n,
  output logic       dce,
  output logic       iochrdy,
  output logic [1:0] reg_sel,
  output logic       wr_strobe,
  output logic       rd_strobe,
  output logic       busy,
  output logic       strobe_err
);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAccess,
    StHold,
    StRecover
  } state_e;

  state_e     state_q, state_d;
  logic       ior_meta_q, ior_s;
  logic       iow_meta_q, iow_s;
  logic [3:0] cnt_q, cnt_d;
  logic       dir_q, dir_d;          // 1 = write cycle
  logic [1:0] reg_sel_q, reg_sel_d;
  logic       err_q, err_d;
  logic       armed_q, armed_d;      // both strobes seen high since last cycle/reset
  logic [1:0] flush_q;               // synchronizers hold reset value for two edges

  logic both_low;
  logic both_high;
  logic match;
  logic active_high;

  // Strobe synchronizers; idle (high) during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ior_meta_q <= 1'b1;
      ior_s      <= 1'b1;
      iow_meta_q <= 1'b1;
      iow_s      <= 1'b1;
      flush_q    <= 2'b00;
    end else begin
      ior_meta_q <= ior_n;
      ior_s      <= ior_meta_q;
      iow_meta_q <= iow_n;
      iow_s      <= iow_meta_q;
      flush_q    <= {flush_q[0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      dir_q     <= 1'b0;
      reg_sel_q <= 2'd0;
      err_q     <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      reg_sel_q <= reg_sel_d;
      err_q     <= err_d;
      armed_q   <= armed_d;
    end
  end

  assign both_low    = !ior_s && !iow_s;
  assign both_high   = ior_s && iow_s;
  assign match       = !aen && (isa_addr[9:2] == BASE_ADDR[9:2]);
  assign active_high = dir_q ? iow_s : ior_s;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    reg_sel_d = reg_sel_q;
    err_d     = err_q;
    armed_d   = armed_q;
    cs_n      = 1'b1;
    iochrdy   = 1'b1;
    dce       = 1'b0;
    wr_strobe = 1'b0;
    rd_strobe = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (both_low) begin
          err_d   = 1'b1;
          armed_d = 1'b0;
        end else if (both_high) begin
          // Arm only once the synchronizers reflect the real pins after reset.
          armed_d = flush_q[1];
        end else if (armed_q) begin
          // First cycle a single strobe is seen low: decode exactly once.
          armed_d = 1'b0;
          if (match) begin
            reg_sel_d = isa_addr[1:0];
            dir_d     = !iow_s;
            // Direction is driven during this cs_n-high cycle so it is settled
            // before the transceiver is enabled.
            dce       = !iow_s;
            state_d   = StSetup;
          end
        end
      end

      StSetup: begin
        cs_n      = 1'b0;
        iochrdy   = 1'b0;
        dce       = dir_q;
        rd_strobe = !dir_q;
        cnt_d     = 4'(WAIT_CYCLES);
        if (both_low) begin
          err_d   = 1'b1;
          state_d = StRecover;
        end else if (active_high) begin
          state_d = StRecover;
        end else begin
          state_d = StAccess;
        end
      end

      StAccess: begin
        cs_n    = 1'b0;
        iochrdy = 1'b0;
        dce     = dir_q;
        if (both_low) begin
          err_d   = 1'b1;
          state_d = StRecover;
        end else if (active_high) begin
          state_d = StRecover;
        end else if (cnt_q == 4'd0) begin
          wr_strobe = dir_q;
          state_d   = StHold;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      StHold: begin
        cs_n = 1'b0;
        dce  = dir_q;
        if (both_low) begin
          err_d   = 1'b1;
          state_d = StRecover;
        end else if (active_high) begin
          state_d = StRecover;
        end
      end

      StRecover: begin
        dir_d   = 1'b0;
        armed_d = 1'b0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign reg_sel    = reg_sel_q;
  assign busy       = (state_q != StIdle);
  assign strobe_err = err_q;

endmodule

// File: tb/tb_isa_xcvr_controller.sv
// Directed testbench for isa_xcvr_controller (default parameters).
module tb_isa_xcvr_controller;

  logic       clk;
  logic       rst;
  logic [9:0] isa_addr;
  logic       aen;
  logic       ior_n;
  logic       iow_n;
  logic       cs_n;
  logic       dce;
  logic       iochrdy;
  logic [1:0] reg_sel;
  logic       wr_strobe;
  logic       rd_strobe;
  logic       busy;
  logic       strobe_err;

  int checks;
  int errors;

  isa_xcvr_controller #(
    .BASE_ADDR  (10'h300),
    .WAIT_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .isa_addr  (isa_addr),
    .aen       (aen),
    .ior_n     (ior_n),
    .iow_n     (iow_n),
    .cs_n      (cs_n),
    .dce       (dce),
    .iochrdy   (iochrdy),
    .reg_sel   (reg_sel),
    .wr_strobe (wr_strobe),
    .rd_strobe (rd_strobe),
    .busy      (busy),
    .strobe_err(strobe_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // Advance to 1 ns after the next rising edge; sample and drive there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ior_n = 1'b1; iow_n = 1'b1; isa_addr = 10'h000; aen = 1'b0;
    #2;
    checks++;
    if ({cs_n, iochrdy, dce, reg_sel, wr_strobe, rd_strobe, busy, strobe_err} !== 9'b110000000) begin
      errors++;
      $display("FAIL reset_outputs: got cs_n=%b iochrdy=%b dce=%b reg_sel=%0d wr=%b rd=%b busy=%b err=%b expected 1 1 0 0 0 0 0 0",
               cs_n, iochrdy, dce, reg_sel, wr_strobe, rd_strobe, busy, strobe_err);
    end
    idle_cycles(3);
    rst = 1'b0;
    idle_cycles(5);
  endtask

  task automatic test_write();
    int   first_cs, rise_cs, rdy_low, wr_cnt, rd_cnt, bad;
    logic dce_pre;
    first_cs = -1; rise_cs = -1; rdy_low = 0; wr_cnt = 0; rd_cnt = 0; bad = 0; dce_pre = 1'b0;
    isa_addr = 10'h302; aen = 1'b0; iow_n = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (cs_n === 1'b0 && first_cs < 0) first_cs = i;
      if (first_cs >= 0 && rise_cs < 0 && cs_n === 1'b1) rise_cs = i;
      if (i == 2) dce_pre = dce;
      if (iochrdy === 1'b0) rdy_low++;
      if (wr_strobe === 1'b1) wr_cnt++;
      if (rd_strobe === 1'b1) rd_cnt++;
      if (cs_n === 1'b0 && (dce !== 1'b1 || reg_sel !== 2'd2)) bad++;
      if (i == 20) iow_n = 1'b1;
    end
    check_int("write_cs_latency", first_cs, 3);
    check_int("write_dce_before_cs", int'(dce_pre), 1);
    check_int("write_iochrdy_low", rdy_low, 6);
    check_int("write_wr_pulses", wr_cnt, 1);
    check_int("write_rd_pulses", rd_cnt, 0);
    check_int("write_dce_regsel_during_cs", bad, 0);
    check_int("write_cs_release", rise_cs, 23);
    check_int("write_busy_end", int'(busy), 0);
  endtask

  task automatic test_read();
    int first_cs, first_rd, rdy_low, wr_cnt, rd_cnt, dce_hi, bad;
    first_cs = -1; first_rd = -1; rdy_low = 0; wr_cnt = 0; rd_cnt = 0; dce_hi = 0; bad = 0;
    isa_addr = 10'h301; aen = 1'b0; ior_n = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (cs_n === 1'b0 && first_cs < 0) first_cs = i;
      if (rd_strobe === 1'b1 && first_rd < 0) first_rd = i;
      if (iochrdy === 1'b0) rdy_low++;
      if (wr_strobe === 1'b1) wr_cnt++;
      if (rd_strobe === 1'b1) rd_cnt++;
      if (dce !== 1'b0) dce_hi++;
      if (cs_n === 1'b0 && reg_sel !== 2'd1) bad++;
      if (i == 20) ior_n = 1'b1;
    end
    check_int("read_cs_latency", first_cs, 3);
    check_int("read_rd_in_setup", first_rd, 3);
    check_int("read_rd_pulses", rd_cnt, 1);
    check_int("read_wr_pulses", wr_cnt, 0);
    check_int("read_iochrdy_low", rdy_low, 6);
    check_int("read_dce_high_cycles", dce_hi, 0);
    check_int("read_regsel", bad, 0);
  endtask

  task automatic test_no_match();
    int cs_low, busy_hi;
    cs_low = 0; busy_hi = 0;
    isa_addr = 10'h310; aen = 1'b0; iow_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (cs_n !== 1'b1) cs_low++;
      if (busy !== 1'b0) busy_hi++;
    end
    iow_n = 1'b1;
    idle_cycles(5);
    check_int("nomatch_addr_cs_low", cs_low, 0);
    check_int("nomatch_addr_busy", busy_hi, 0);
    cs_low = 0; busy_hi = 0;
    isa_addr = 10'h300; aen = 1'b1; ior_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (cs_n !== 1'b1) cs_low++;
      if (busy !== 1'b0) busy_hi++;
    end
    ior_n = 1'b1; aen = 1'b0;
    idle_cycles(5);
    check_int("nomatch_aen_cs_low", cs_low, 0);
    check_int("nomatch_aen_busy", busy_hi, 0);
  endtask

  task automatic test_abort();
    int   rise_cs, rdy_low, wr_cnt;
    logic dce_rec, rdy_rec, busy_rec, busy_after;
    rise_cs = -1; rdy_low = 0; wr_cnt = 0;
    dce_rec = 1'bx; rdy_rec = 1'bx; busy_rec = 1'bx; busy_after = 1'bx;
    isa_addr = 10'h300; aen = 1'b0; iow_n = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (i >= 3 && rise_cs < 0 && cs_n === 1'b1) rise_cs = i;
      if (iochrdy === 1'b0) rdy_low++;
      if (wr_strobe === 1'b1) wr_cnt++;
      if (i == 8) begin dce_rec = dce; rdy_rec = iochrdy; busy_rec = busy; end
      if (i == 9) busy_after = busy;
      if (i == 5) iow_n = 1'b1;
    end
    check_int("abort_cs_release", rise_cs, 8);
    check_int("abort_wr_pulses", wr_cnt, 0);
    check_int("abort_iochrdy_low", rdy_low, 5);
    check_int("abort_recover_dce", int'(dce_rec), 0);
    check_int("abort_recover_iochrdy", int'(rdy_rec), 1);
    check_int("abort_recover_busy", int'(busy_rec), 1);
    check_int("abort_idle_busy", int'(busy_after), 0);
  endtask

  task automatic test_strobe_err();
    int cs_low, busy_hi;
    cs_low = 0; busy_hi = 0;
    isa_addr = 10'h300; aen = 1'b0; ior_n = 1'b0; iow_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (cs_n !== 1'b1) cs_low++;
      if (busy !== 1'b0) busy_hi++;
    end
    check_int("err_cs_low", cs_low, 0);
    check_int("err_busy", busy_hi, 0);
    check_int("err_set", int'(strobe_err), 1);
    ior_n = 1'b1; iow_n = 1'b1;
    idle_cycles(5);
    check_int("err_sticky", int'(strobe_err), 1);
    rst = 1'b1;
    #1;
    check_int("err_cleared_by_rst", int'(strobe_err), 0);
    step();
    rst = 1'b0;
    idle_cycles(5);
  endtask

  task automatic test_reset_mid_access();
    int   cs_low, first_cs;
    logic cs_pre;
    cs_low = 0; first_cs = -1;
    isa_addr = 10'h303; aen = 1'b0; iow_n = 1'b0;
    idle_cycles(5);
    cs_pre = cs_n;
    check_int("rstmid_in_access", int'(cs_pre), 0);
    rst = 1'b1;
    #1;
    check_int("rstmid_cs_released", int'(cs_n), 1);
    check_int("rstmid_iochrdy_released", int'(iochrdy), 1);
    check_int("rstmid_busy", int'(busy), 0);
    idle_cycles(2);
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (cs_n !== 1'b1) cs_low++;
    end
    check_int("rstmid_no_retrigger", cs_low, 0);
    iow_n = 1'b1;
    idle_cycles(5);
    iow_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (cs_n === 1'b0 && first_cs < 0) first_cs = i;
    end
    iow_n = 1'b1;
    idle_cycles(8);
    check_int("rstmid_restart_latency", first_cs, 3);
    check_int("rstmid_final_idle", int'(busy), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write();
    test_read();
    test_no_match();
    test_abort();
    test_strobe_err();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
